// File: rtl/aes_pkg.sv
// Shared AES-128 primitives: S-box, GF(2^8) xtime, round constants and one-column MixColumns.
package aes_pkg;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] s;
      s = 8'h00;
      case (b)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bits [31:24] hold row 0.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes128_if.sv
// Key-in / ciphertext-out bus of the AES-128 pipeline.
interface aes128_if;
   logic [127:0] key;
   logic [127:0] out;

   modport master (output key, input out);
   modport slave  (input key, output out);
endinterface

// File: rtl/aes128_round_stage.sv
// One AES-128 pipeline stage: expands the previous round key and applies one round with it.
module aes128_round_stage
   import aes_pkg::*;
#(
   parameter logic [7:0] RC    = 8'h01,
   parameter bit         FINAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state_in,
   input  logic [127:0] key_in,
   output logic [127:0] state_out,
   output logic [127:0] key_out
);

   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [31:0]  temp, w0, w1, w2, w3;
   logic [127:0] sub_shift;
   logic [127:0] mixed;

   always_comb begin
      temp = {sbox(key_in[23:16]), sbox(key_in[15:8]), sbox(key_in[7:0]), sbox(key_in[31:24])}
             ^ {RC, 24'h000000};
      w0 = key_in[127:96] ^ temp;
      w1 = key_in[95:64] ^ w0;
      w2 = key_in[63:32] ^ w1;
      w3 = key_in[31:0] ^ w2;
      key_d = {w0, w1, w2, w3};

      // Row r of column c takes the byte from column (c + r) mod 4.
      sub_shift = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub_shift[127 - 8*(4*c + r) -: 8] = sbox(state_in[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
      end

      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[127 - 32*c -: 32] = mix_column(sub_shift[127 - 32*c -: 32]);
      end

      state_d = (FINAL ? sub_shift : mixed) ^ key_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

   assign state_out = state_q;
   assign key_out   = key_q;

endmodule

// File: rtl/aes128.sv
// Fully pipelined AES-128 encryption of a fixed plaintext; one key per clock, ciphertext 10 clocks later.
module aes128
   import aes_pkg::*;
#(
   parameter logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff
) (
   input logic     clk,
   input logic     rst,
   aes128_if.slave bus
);

   logic [127:0] s0_q, s0_d;
   logic [127:0] k0_q, k0_d;
   logic [127:0] state_pipe [0:10];
   logic [127:0] key_pipe [0:9];
   logic [127:0] key_unused;

   always_comb begin
      s0_d = PLAINTEXT ^ bus.key;
      k0_d = bus.key;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q <= '0;
         k0_q <= '0;
      end else begin
         s0_q <= s0_d;
         k0_q <= k0_d;
      end
   end

   assign state_pipe[0] = s0_q;
   assign key_pipe[0]   = k0_q;

   // The last stage's round key has no consumer.
   for (genvar r = 1; r <= 10; r++) begin : g_round
      if (r < 10) begin : g_mid
         aes128_round_stage #(.RC(RCON[r]), .FINAL(1'b0)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .state_in (state_pipe[r-1]),
            .key_in   (key_pipe[r-1]),
            .state_out(state_pipe[r]),
            .key_out  (key_pipe[r])
         );
      end else begin : g_last
         aes128_round_stage #(.RC(RCON[r]), .FINAL(1'b1)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .state_in (state_pipe[r-1]),
            .key_in   (key_pipe[r-1]),
            .state_out(state_pipe[r]),
            .key_out  (key_unused)
         );
      end
   end

   assign bus.out = state_pipe[10];

endmodule

// File: tb/tb_aes128.sv
// Bench for aes128: known-answer table, back-to-back, random stream, latency and async reset sequences.
module tb_aes128;

   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes128_if if_c ();
   aes128_if if_z ();
   aes128_if if_b ();

   aes128 #(.PLAINTEXT(PT_C))   u_dut_c (.clk(clk), .rst(rst), .bus(if_c));
   aes128 #(.PLAINTEXT(128'h0)) u_dut_z (.clk(clk), .rst(rst), .bus(if_z));
   aes128 #(.PLAINTEXT(PT_B))   u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

   typedef struct {
      int           sel;
      logic [127:0] key;
      logic [127:0] exp;
      string        name;
   } vec_t;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   sb [256];
   logic [127:0] hist [$];
   logic [127:0] due_key;
   bit           due_ok;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p, x;
      p = 0;
      x = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
         if ((x & 256) != 0) x = x ^ 'h11b;
      end
      return p[7:0];
   endfunction

   function automatic int rotl8(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 255;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         int inv, s;
         inv = 0;
         for (int y = 1; y < 256 && x != 0; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = y;
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
         sb[x] = s[7:0];
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [7:0]   rk [176];
      logic [7:0]   t0, t1, t2, t3, rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         st[i] = pt[127 - 8*i -: 8];
         rk[i] = key[127 - 8*i -: 8];
      end
      for (int i = 16; i < 176; i += 4) begin
         t0 = rk[i-4]; t1 = rk[i-3]; t2 = rk[i-2]; t3 = rk[i-1];
         if (i % 16 == 0) begin
            {t0, t1, t2, t3} = {sb[t1] ^ rc, sb[t2], sb[t3], sb[t0]};
            rc = gmul(rc, 8'h02);
         end
         rk[i]   = rk[i-16] ^ t0;
         rk[i+1] = rk[i-15] ^ t1;
         rk[i+2] = rk[i-14] ^ t2;
         rk[i+3] = rk[i-13] ^ t3;
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++)
            tmp[i] = sb[st[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  st[4*c + r] = gmul(tmp[4*c + r], 8'h02) ^ gmul(tmp[4*c + (r+1)%4], 8'h03)
                              ^ tmp[4*c + (r+2)%4] ^ tmp[4*c + (r+3)%4];
         end else begin
            for (int i = 0; i < 16; i++) st[i] = tmp[i];
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*rnd + i];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
      return res;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
      checks++;
      if (act === bad) begin
         errors++;
         $display("FAIL %s: got %h, expected anything but %h", name, act, bad);
      end
   endtask

   function automatic logic [127:0] sel_out(input int sel);
      case (sel)
         0:       return if_c.out;
         1:       return if_z.out;
         default: return if_b.out;
      endcase
   endfunction

   // Called at a falling edge; presents k to all DUTs across one rising edge and returns at the next falling edge.
   task automatic apply(input logic [127:0] k);
      if_c.key = k;
      if_z.key = k;
      if_b.key = k;
      @(posedge clk);
      #1;
      hist.push_back(k);
      due_ok = 1'b0;
      if (hist.size() > 10) begin
         due_key = hist.pop_front();
         due_ok  = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic check_stream(input string tag);
      if (due_ok) begin
         check({tag, "_c"}, if_c.out, aes_ref(PT_C, due_key));
         check({tag, "_z"}, if_z.out, aes_ref(128'h0, due_key));
         check({tag, "_b"}, if_b.out, aes_ref(PT_B, due_key));
      end
   endtask

   task automatic async_reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_c", if_c.out, '0);
      check("rst_async_z", if_z.out, '0);
      check("rst_async_b", if_b.out, '0);
      @(posedge clk);
      #1;
      check("rst_held_c", if_c.out, '0);
      @(negedge clk);
      rst = 1'b0;
      hist.delete();
      due_ok = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      vec_t vecs [3];
      logic [127:0] k;

      vecs[0].sel = 0; vecs[0].key = KEY_C; vecs[0].exp = CT_C;  vecs[0].name = "fips_c1";
      vecs[1].sel = 2; vecs[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      vecs[1].exp = 128'h3925841d02dc09fbdc118597196a0b32;       vecs[1].name = "fips_b";
      vecs[2].sel = 1; vecs[2].key = 128'h0;  vecs[2].exp = CT_Z;  vecs[2].name = "zero";

      due_ok = 1'b0;
      due_key = '0;
      rst = 1'b1;
      if_c.key = '0;
      if_z.key = '0;
      if_b.key = '0;
      build_sbox();
      #12;
      check("reset_c", if_c.out, '0);
      check("reset_z", if_z.out, '0);
      check("reset_b", if_b.out, '0);
      @(negedge clk);
      rst = 1'b0;

      // Known-answer table: hold each key; ciphertext from the 10th edge after it is first sampled.
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 12; i++) begin
            apply(vecs[v].key);
            if (i >= 10) check({vecs[v].name, "_kat"}, sel_out(vecs[v].sel), vecs[v].exp);
            if (i == 10) check_stream({vecs[v].name, "_model"});
         end
      end

      // Back-to-back alternating keys on the zero-plaintext instance.
      for (int i = 0; i < 24; i++) begin
         apply((i % 2 == 0) ? 128'h0 : KEY_C);
         if (due_ok) check("b2b_z", if_z.out, (due_key == 128'h0) ? CT_Z : aes_ref(128'h0, KEY_C));
      end

      // Random independent keys every clock.
      for (int i = 0; i < 40; i++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         apply(k);
         check_stream("rand");
      end

      // Single-cycle key pulse at relative edge 11 must appear at edge 21 only.
      for (int i = 0; i < 24; i++) begin
         apply((i == 11) ? 128'h0 : KEY_C);
         if (i == 20) check("lat_before", if_c.out, CT_C);
         if (i == 21) check("lat_pulse", if_c.out, aes_ref(PT_C, 128'h0));
         if (i == 22) check("lat_after", if_c.out, CT_C);
      end

      // Mid-stream asynchronous reset discards in-flight keys.
      for (int i = 0; i < 15; i++) begin
         apply({$urandom(), $urandom(), $urandom(), $urandom()});
         check_stream("pre_rst");
      end
      async_reset_pulse();
      for (int i = 0; i < 12; i++) begin
         apply(KEY_C);
         if (i == 9) check_ne("post_rst_early", if_c.out, CT_C);
         if (i >= 10) check("post_rst_ct", if_c.out, CT_C);
         if (i == 11) check_stream("post_rst_model");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
